relu_sched: RTL
===============

# relu_sched

Sequencing controller for the 4-lane ReLU stage of the CNN accelerator. It accepts a serial stream of signed pre-activation values, packs them four at a time, issues each group to the ReLU unit, and writes the rectified 4-lane result to the activation buffer at an incrementing address. One `start` processes one layer of `num_elems` values. A partial final group is zero-padded and masked.

## Interface
- `RELU_SIZE`, 21: datapath width of one signed value.
- `ADDR_W`, 10: activation-buffer word address width. It also sets the element-count width.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a layer; sampled only in IDLE.
- `num_elems`  in  ADDR_W+2: element count; sampled when `start` is accepted.
- `s_valid`  in  1: input value valid.
- `s_data`  in  RELU_SIZE signed: input value.
- `s_ready`  out  1: controller accepts `s_data`.
- `relu_in_ready`  out  1: one-cycle issue strobe to the ReLU unit.
- `relu_in0..relu_in3`  out  RELU_SIZE signed each: lane operands.
- `relu_ready`  in  1: ReLU result valid; the ReLU unit drives it exactly 1 cycle after `relu_in_ready`.
- `relu_out0..relu_out3`  in  RELU_SIZE signed each: lane results.
- `wr_en`  out  1: buffer write strobe.
- `wr_addr`  out  ADDR_W: buffer word address, one word per group.
- `wr_data`  out  4*RELU_SIZE: {lane3, lane2, lane1, lane0}.
- `wr_mask`  out  4: valid lanes of this word; bit i = lane i.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at layer completion.

## Operation
- Reset: state IDLE. All outputs 0. Lane registers, counters and `wr_addr` are cleared.
- IDLE
  - `start`=1: latch `num_elems` and clear the counters.
  - If `num_elems`==0, go to DONE. Otherwise go to FILL.
- FILL
  - `s_ready`=1.
  - On each `s_valid && s_ready`: write `s_data` into lane `lane_cnt`, then increment `lane_cnt` and `elem_cnt`.
  - Go to ISSUE on the handshake that fills lane 3, or on the handshake where `elem_cnt+1 == num_elems`.
  - `s_ready` drops in the cycle after that handshake.
- ISSUE
  - `relu_in_ready`=1 for exactly one cycle. `relu_in0..3` carry the lane registers; lanes not filled in this group are 0.
  - Next state is WAIT.
- WAIT
  - Hold until `relu_ready`=1.
  - On that cycle, capture {`relu_out3`..`relu_out0`} into the write register and set the mask to the filled-lane count (e.g. 2 lanes → 4'b0011).
  - Next state is WRITE.
- WRITE
  - `wr_en`=1 for one cycle, with `wr_addr` = group index.
  - Then `wr_addr` increments and the lane registers and `lane_cnt` clear.
  - Go to DONE if `elem_cnt == num_elems`, else back to FILL.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- `rst` at any time aborts the layer. No write is issued after the reset cycle.
- Width rule: data is not modified by the controller; it passes through unmodified. `wr_addr` wraps modulo 2^ADDR_W. A `num_elems` larger than 4·2^ADDR_W is out of range; the caller must not apply it.

## Timing
- From `start` accepted in cycle T: FILL in T+1, with `s_ready` high in T+1.
- Full group:
  - the 4th handshake at cycle F;
  - ISSUE at F+1;
  - WAIT (with `relu_ready`) at F+2;
  - WRITE with `wr_en` at F+3;
  - next FILL at F+4.
- Sustained throughput with `s_valid` held high: 4 values per 7 cycles.
- `done` comes 1 cycle after the last WRITE. `busy` falls in the same cycle the state returns to IDLE.
- `num_elems`=0: `done` at T+1, with no writes and no issue strobe.

## Structure
- Package `relu_sched_pkg`:
  - state encoding (IDLE, FILL, ISSUE, WAIT, WRITE, DONE);
  - `LANES`=4;
  - lane-count/mask helper constants.
- One natural sub-module, `relu_lane_pack`: the lane registers, `lane_cnt`, zero-padding and mask generation.
- The FSM, element counter and address counter stay in the top level.
- The ReLU unit is instantiated by the parent, not inside this block.

## Test plan
- `num_elems`=4, inputs {5,-3,7,-1}, `s_valid` constant → one write at addr 0, data {0,7,0,5}, mask 4'b1111, `done` 7 cycles after the first accepted value's FILL cycle.
- `num_elems`=6, inputs {1,2,3,4,-5,6} → addr 0 {4,3,2,1} mask 4'b1111; addr 1 {0,0,6,0} mask 4'b0011; exactly two `wr_en` pulses.
- `num_elems`=0 → `done` pulse 1 cycle after `start`; `relu_in_ready` and `wr_en` never assert.
- Random `s_valid` gaps, `num_elems`=9 → 3 writes at addrs 0,1,2 with correct values; `relu_in_ready` never asserts outside ISSUE.
- `start` pulsed during FILL of an 8-element layer → ignored; exactly 2 writes, 1 `done`.
- `rst` asserted in WAIT → next cycle all outputs 0 and state IDLE; no `wr_en`; a fresh `start` of 4 elements writes at addr 0.

Source files
------------

// File: rtl/relu_sched_pkg.sv
// Shared types and constants for the 4-lane ReLU sequencing controller.
package relu_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam int LANES  = 4;
   localparam int LCNT_W = 3;  // counts 0..LANES inclusive
   localparam logic [LCNT_W-1:0] LAST_LANE = LCNT_W'(LANES - 1);

   // Thermometer mask with the low 'cnt' lanes set.
   function automatic logic [LANES-1:0] lane_mask(input logic [LCNT_W-1:0] cnt);
      logic [LANES-1:0] m;
      m = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i < int'(cnt)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/relu_sched_lane_pack.sv
// Lane registers for one group: serial load, fill count, zero-padded lane
// outputs and the matching valid-lane mask.
module relu_lane_pack
   import relu_sched_pkg::*;
#(
   parameter int RELU_SIZE = 21
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load,
   input  logic                                clr,
   input  logic signed [RELU_SIZE-1:0]         data,
   output logic        [LANES-1:0][RELU_SIZE-1:0] lanes,
   output logic        [LCNT_W-1:0]            lane_cnt,
   output logic        [LANES-1:0]             mask
);

   logic [RELU_SIZE-1:0] lane_q [LANES];

   // NOTE: state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
         lane_cnt <= '0;
      end else if (load) begin
         lane_q[lane_cnt[1:0]] <= data;
         lane_cnt              <= lane_cnt + LCNT_W'(1);
      end
   end

   assign mask = lane_mask(lane_cnt);

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lanes[i] = mask[i] ? lane_q[i] : '0;
      end
   end

endmodule

// File: rtl/relu_sched.sv
// Layer sequencer for the 4-lane ReLU stage: packs a serial stream into
// groups, issues each group, and writes the rectified word to the buffer.
module relu_sched
   import relu_sched_pkg::*;
#(
   parameter int RELU_SIZE = 21,
   parameter int ADDR_W    = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ADDR_W+1:0]           num_elems,
   input  logic                        s_valid,
   input  logic signed [RELU_SIZE-1:0] s_data,
   output logic                        s_ready,
   output logic                        relu_in_ready,
   output logic signed [RELU_SIZE-1:0] relu_in0,
   output logic signed [RELU_SIZE-1:0] relu_in1,
   output logic signed [RELU_SIZE-1:0] relu_in2,
   output logic signed [RELU_SIZE-1:0] relu_in3,
   input  logic                        relu_ready,
   input  logic signed [RELU_SIZE-1:0] relu_out0,
   input  logic signed [RELU_SIZE-1:0] relu_out1,
   input  logic signed [RELU_SIZE-1:0] relu_out2,
   input  logic signed [RELU_SIZE-1:0] relu_out3,
   output logic                        wr_en,
   output logic [ADDR_W-1:0]           wr_addr,
   output logic [LANES*RELU_SIZE-1:0]  wr_data,
   output logic [LANES-1:0]            wr_mask,
   output logic                        busy,
   output logic                        done
);

   localparam int CNT_W = ADDR_W + 2;

   state_t                          state;
   logic [CNT_W-1:0]                num_q;
   logic [CNT_W-1:0]                elem_cnt;
   logic [CNT_W-1:0]                elem_next;
   logic                            hs;
   logic [LANES-1:0][RELU_SIZE-1:0] lanes;
   logic [LCNT_W-1:0]               lane_cnt;
   logic [LANES-1:0]                pad_mask;

   assign hs        = (state == S_FILL) && s_valid && s_ready;
   assign elem_next = elem_cnt + CNT_W'(1);
   assign busy      = (state != S_IDLE);

   relu_lane_pack #(.RELU_SIZE(RELU_SIZE)) u_pack (
      .clk      (clk),
      .rst      (rst),
      .load     (hs),
      .clr      (state == S_WRITE),
      .data     (s_data),
      .lanes    (lanes),
      .lane_cnt (lane_cnt),
      .mask     (pad_mask)
   );

   assign relu_in0 = lanes[0];
   assign relu_in1 = lanes[1];
   assign relu_in2 = lanes[2];
   assign relu_in3 = lanes[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         num_q         <= '0;
         elem_cnt      <= '0;
         s_ready       <= 1'b0;
         relu_in_ready <= 1'b0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         wr_mask       <= '0;
         done          <= 1'b0;
      end else begin
         relu_in_ready <= 1'b0;
         wr_en         <= 1'b0;
         done          <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               num_q    <= num_elems;
               elem_cnt <= '0;
               wr_addr  <= '0;
               if (num_elems == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state   <= S_FILL;
                  s_ready <= 1'b1;
               end
            end
            S_FILL: if (hs) begin
               elem_cnt <= elem_next;
               // Close the group on lane 3 or on the layer's last element.
               if (lane_cnt == LAST_LANE || elem_next == num_q) begin
                  state         <= S_ISSUE;
                  s_ready       <= 1'b0;
                  relu_in_ready <= 1'b1;
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: if (relu_ready) begin
               wr_data <= {relu_out3, relu_out2, relu_out1, relu_out0};
               wr_mask <= pad_mask;
               wr_en   <= 1'b1;
               state   <= S_WRITE;
            end
            S_WRITE: begin
               wr_addr <= wr_addr + ADDR_W'(1);
               if (elem_cnt == num_q) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state   <= S_FILL;
                  s_ready <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
